bus_demux1to3: RTL and testbench
================================

BUS_DEMUX1TO3 -- requirements
Module: bus_demux1to3

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data path width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  WIDTH  source word.
REQ-005 SHALL have port in_sel  input  2  destination: 00=A, 01=B, 10=C, 11=broadcast/illegal.
REQ-006 SHALL have port in_valid  input  1  source word present.
REQ-007 SHALL have port in_ready  output  1  word accepted this cycle when in_valid also high.
REQ-008 SHALL have ports out_a_data, out_b_data, out_c_data  output  WIDTH  registered destination words.
REQ-009 SHALL have ports out_a_valid, out_b_valid, out_c_valid  output  1  destination slot holds a word.
REQ-010 SHALL have ports out_a_ready, out_b_ready, out_c_ready  input  1  destination consumes word this cycle.
REQ-011 SHALL have port err  output  1  sticky illegal-select flag.

Function
REQ-012 SHALL hold one-entry slot per destination (data register + valid bit); transfer out = out_X_valid && out_X_ready.
REQ-013 SHALL define slot X "free" = !out_X_valid || out_X_ready.
REQ-014 SHALL drive in_ready combinationally: sel 00/01/10 -> selected slot free; sel 11 -> per REQ-025/026; forced 0 while rst high.
REQ-015 SHALL accept a word on a rising edge where in_valid && in_ready; no other input transfer occurs.
REQ-016 SHALL make an accepted word visible on out_X_data with out_X_valid=1 immediately after the accepting edge (1-cycle latency).
REQ-017 SHALL hold out_X_data stable while out_X_valid=1 and out_X_ready=0.
REQ-018 SHALL clear out_X_valid after an output transfer when no new word is loaded into X on that edge.
REQ-019 SHALL, on simultaneous output transfer and load of slot X, keep out_X_valid=1 and replace data (full throughput, 1 word/cycle/slot).
REQ-020 SHALL operate the three slots independently; a stalled slot SHALL NOT block words for other slots.
REQ-021 SHALL NOT modify out_X_data when slot X is not loaded; contents of an empty slot are don't-care but SHALL NOT change without a load.
REQ-022 SHALL preserve in_data bit-exact; no width conversion.

Reset
REQ-023 SHALL, on rising edge with rst=1, set out_a/b/c_valid=0, out_a/b/c_data=0, err=0, discarding any held words regardless of handshake state.
REQ-024 SHALL resume accepting on the first edge after rst returns low; reset asserted mid-stream loses held words without output transfer.

Configuration
REQ-025 SHALL, with macro DEMUX_BROADCAST_EN defined, treat sel 11 as broadcast: in_ready = all three slots free; on accept load the word into A, B and C on the same edge; err tied 0.
REQ-026 SHALL, without DEMUX_BROADCAST_EN, treat sel 11 as illegal: in_ready=1, word discarded, no slot changes, err set to 1 on the accepting edge and held until reset.

Verification
REQ-027 SHALL cover reset: rst=1 one edge with slots previously full -> all out_*_valid=0, out_*_data=0000, err=0, in_ready=0 during rst.
REQ-028 SHALL cover routing: in_data=DDDD sel=01 valid, out_b_ready=0 -> after edge out_b_valid=1 out_b_data=DDDD, out_a/c_valid=0; next word sel=01 -> in_ready=0 until out_b_ready=1.
REQ-029 SHALL cover back-to-back: sel=10 words 0001,0002,0003 on consecutive edges with out_c_ready=1 -> out_c_data 0001,0002,0003 on consecutive cycles, out_c_valid continuously 1.
REQ-030 SHALL cover independence: slot A full and stalled (out_a_ready=0), send EEEE sel=10 -> accepted, out_c_data=EEEE, out_a_data unchanged.
REQ-031 SHALL cover sel=11 without DEMUX_BROADCAST_EN: in_data=FFFF -> in_ready=1, no slot valid changes, err=1 sticky until rst.
REQ-032 SHALL cover sel=11 with DEMUX_BROADCAST_EN: 2222 while slot B stalled full -> in_ready=0; release out_b_ready -> on that edge all three slots load 2222, err=0.

Source files
------------

// File: rtl/bus_demux1to3.sv
// One-to-three bus demultiplexer with a one-entry registered slot per destination.
// Optional macro DEMUX_BROADCAST_EN turns select 2'b11 into a broadcast to all slots.
module bus_demux1to3 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic [WIDTH-1:0] out_b_data,
    output logic [WIDTH-1:0] out_c_data,
    output logic             out_a_valid,
    output logic             out_b_valid,
    output logic             out_c_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    input  logic             out_c_ready,
    output logic             err
);

    // Slot index 0/1/2 maps to destination A/B/C.
    logic [2:0][WIDTH-1:0] data_q;
    logic [2:0][WIDTH-1:0] data_d;
    logic [2:0]            valid_q;
    logic [2:0]            valid_d;
    logic                  err_q;
    logic                  err_d;

    logic [2:0]            out_ready_s;
    logic [2:0]            free_s;
    logic [2:0]            load_s;
    logic                  in_ready_s;
    logic                  accept_s;
`ifndef DEMUX_BROADCAST_EN
    logic                  illegal_s;
`endif

    assign out_ready_s = {out_c_ready, out_b_ready, out_a_ready};
    assign free_s      = ~valid_q | out_ready_s;

    // Input handshake: a word is accepted only when its target slot(s) can take it.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (in_sel)
                2'b00:   in_ready_s = free_s[0];
                2'b01:   in_ready_s = free_s[1];
                2'b10:   in_ready_s = free_s[2];
`ifdef DEMUX_BROADCAST_EN
                2'b11:   in_ready_s = &free_s;
`else
                2'b11:   in_ready_s = 1'b1;
`endif
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Decode which slots load on this edge; an illegal select is swallowed and flagged.
    always_comb begin
        load_s = 3'b000;
`ifndef DEMUX_BROADCAST_EN
        illegal_s = 1'b0;
`endif
        if (accept_s) begin
            case (in_sel)
                2'b00:   load_s = 3'b001;
                2'b01:   load_s = 3'b010;
                2'b10:   load_s = 3'b100;
`ifdef DEMUX_BROADCAST_EN
                2'b11:   load_s = 3'b111;
`else
                2'b11:   illegal_s = 1'b1;
`endif
                default: load_s = 3'b000;
            endcase
        end else begin
            load_s = 3'b000;
        end
    end

    // Next-state for each slot: a load wins over a drain so a slot sustains one word per cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < 3; i++) begin
            if (load_s[i]) begin
                data_d[i]  = in_data;
                valid_d[i] = 1'b1;
            end else if (out_ready_s[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
`ifdef DEMUX_BROADCAST_EN
        err_d = 1'b0;
`else
        err_d = err_q | illegal_s;
`endif
    end

    // State registers with synchronous reset that discards any held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_a_data  = data_q[0];
    assign out_b_data  = data_q[1];
    assign out_c_data  = data_q[2];
    assign out_a_valid = valid_q[0];
    assign out_b_valid = valid_q[1];
    assign out_c_valid = valid_q[2];
    assign err         = err_q;

endmodule

// File: tb/tb_bus_demux1to3.sv
// Scoreboard bench for bus_demux1to3: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the three destination slots.
module tb_bus_demux1to3;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a_data, out_b_data, out_c_data;
    logic             out_a_valid, out_b_valid, out_c_valid;
    logic             out_a_ready, out_b_ready, out_c_ready;
    logic             err;

    always #5 clk = ~clk;

    bus_demux1to3 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_a_data(out_a_data), .out_b_data(out_b_data), .out_c_data(out_c_data),
        .out_a_valid(out_a_valid), .out_b_valid(out_b_valid), .out_c_valid(out_c_valid),
        .out_a_ready(out_a_ready), .out_b_ready(out_b_ready), .out_c_ready(out_c_ready),
        .err(err)
    );

    // Reference model: each destination is a queue of words awaiting consumption.
    logic [WIDTH-1:0] exp_q [3][$];
    logic [WIDTH-1:0] last_word [3];
    bit               exp_err;
    bit               mon_en = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    string            nm [3] = '{"a", "b", "c"};

    logic [2:0]       mv, mr;
    logic [WIDTH-1:0] md [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares slot state and consumes expected words on each output transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            mv = {out_c_valid, out_b_valid, out_a_valid};
            mr = {out_c_ready, out_b_ready, out_a_ready};
            md[0] = out_a_data;
            md[1] = out_b_data;
            md[2] = out_c_data;
            for (int i = 0; i < 3; i++) begin
                check({nm[i], "_valid"}, 32'(mv[i]), 32'(exp_q[i].size() != 0));
                check({nm[i], "_data"}, 32'(md[i]), 32'(last_word[i]));
                if (exp_q[i].size() > 0 && mr[i]) begin
                    check({nm[i], "_xfer"}, 32'(md[i]), 32'(exp_q[i][0]));
                    void'(exp_q[i].pop_front());
                end
            end
            check("err", 32'(err), 32'(exp_err));
        end
    end

    // Model the edge that follows the current inputs; runs after the monitor has drained transfers.
    task automatic model_step();
        bit [2:0] free;
        bit       er;
        for (int i = 0; i < 3; i++) free[i] = (exp_q[i].size() == 0);
        if (rst) er = 1'b0;
        else if (in_sel == 2'd3) begin
`ifdef DEMUX_BROADCAST_EN
            er = &free;
`else
            er = 1'b1;
`endif
        end else er = free[in_sel];
        check("in_ready", 32'(in_ready), 32'(er));
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                exp_q[i].delete();
                last_word[i] = '0;
            end
            exp_err = 1'b0;
        end else if (in_valid && er) begin
            if (in_sel == 2'd3) begin
`ifdef DEMUX_BROADCAST_EN
                for (int i = 0; i < 3; i++) begin
                    exp_q[i].push_back(in_data);
                    last_word[i] = in_data;
                end
`else
                exp_err = 1'b1;
`endif
            end else begin
                exp_q[in_sel].push_back(in_data);
                last_word[in_sel] = in_data;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input bit ra, input bit rb, input bit rc);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_sel = s; in_data = d;
        out_a_ready = ra; out_b_ready = rb; out_c_ready = rc;
        @(negedge clk);
        #1;
        model_step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
        out_a_ready = 1'b0; out_b_ready = 1'b0; out_c_ready = 1'b0;
        for (int i = 0; i < 3; i++) last_word[i] = '0;
        exp_err = 1'b0;
        cycle(1, 0, 2'd0, 16'h0000, 0, 0, 0);
        mon_en = 1'b1;
        cycle(1, 0, 2'd0, 16'h0000, 0, 0, 0);
        // Routing to B with back-pressure
        cycle(0, 1, 2'd1, 16'hDDDD, 0, 0, 0);
        cycle(0, 1, 2'd1, 16'h1234, 0, 0, 0);
        cycle(0, 1, 2'd1, 16'h1234, 0, 0, 0);
        cycle(0, 1, 2'd1, 16'h1234, 0, 1, 0);
        cycle(0, 0, 2'd0, 16'h0000, 0, 1, 0);
        // Back-to-back words to C
        cycle(0, 1, 2'd2, 16'h0001, 0, 0, 1);
        cycle(0, 1, 2'd2, 16'h0002, 0, 0, 1);
        cycle(0, 1, 2'd2, 16'h0003, 0, 0, 1);
        cycle(0, 0, 2'd0, 16'h0000, 0, 0, 1);
        // Stalled A does not block C
        cycle(0, 1, 2'd0, 16'hAAAA, 0, 0, 0);
        cycle(0, 1, 2'd2, 16'hEEEE, 0, 0, 0);
        cycle(0, 1, 2'd0, 16'h5555, 0, 0, 0);
        cycle(0, 0, 2'd0, 16'h0000, 1, 0, 1);
        // Select 11, then with B stalled full
        cycle(0, 1, 2'd3, 16'hFFFF, 0, 0, 0);
        cycle(0, 0, 2'd0, 16'h0000, 0, 0, 0);
        cycle(0, 1, 2'd1, 16'h7777, 0, 0, 0);
        cycle(0, 1, 2'd3, 16'h2222, 1, 0, 1);
        cycle(0, 1, 2'd3, 16'h2222, 1, 1, 1);
        cycle(0, 0, 2'd0, 16'h0000, 1, 1, 1);
        // Reset with all slots full
        cycle(0, 1, 2'd0, 16'h1111, 0, 0, 0);
        cycle(0, 1, 2'd1, 16'h2345, 0, 0, 0);
        cycle(0, 1, 2'd2, 16'h3456, 0, 0, 0);
        cycle(1, 1, 2'd0, 16'h9999, 1, 1, 1);
        cycle(0, 0, 2'd0, 16'h0000, 0, 0, 0);
        // Randomized traffic with occasional mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(9) < 7),
                  2'($urandom_range(3)), 16'($urandom),
                  ($urandom_range(9) < 6), ($urandom_range(9) < 6), ($urandom_range(9) < 6));
        end
        cycle(0, 0, 2'd0, 16'h0000, 1, 1, 1);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
